btb_update_ctrl: RTL and testbench
==================================

# btb_update_ctrl

Write-port sequencer for the branch target buffer. Accepts resolved-taken-branch updates from two branch-resolution requesters, arbitrates round-robin, buffers them in a small FIFO and drives the BTB's single write port (we / jmpsrc / jmpdst) one update per cycle. It sits between the branch execution units and the BTB, and supports a write-block input and a pipeline flush.

## Interface
- ADDR_LEN, 32, address width of branch source and destination
- DEPTH, 4, FIFO entries (power of two, >= 2)
- CNT_W, 3, width of occupancy count (log2(DEPTH)+1)

- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- req0_valid  in  1  requester 0 has an update
- req0_src  in  ADDR_LEN  requester 0 branch PC
- req0_dst  in  ADDR_LEN  requester 0 branch target
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid, req1_src, req1_dst, req1_ready  same as requester 0
- flush  in  1  discard all buffered updates
- wr_block  in  1  inhibit BTB writes this cycle
- btb_we  out  1  BTB write enable (registered)
- btb_jmpsrc  out  ADDR_LEN  BTB write source PC (registered)
- btb_jmpdst  out  ADDR_LEN  BTB write target (registered)
- count  out  CNT_W  current FIFO occupancy (registered)

## Operation
- Handshake: transfer occurs when reqN_valid & reqN_ready at posedge. At most one request accepted per cycle.
- Arbitration: 1-bit priority pointer prio. Both valid -> grant prio; one valid -> grant that one. After a transfer, prio becomes the non-granted index. prio unchanged when no transfer.
- reqN_ready = granted & ~full & ~flush & ~reset. The non-granted requester sees ready=0 and must hold its valid/src/dst.
- full = (count == DEPTH). No enqueue when full, even if a dequeue happens in the same cycle.
- Coalesce: if the granted src equals the tail entry's src, the tail is valid and is not being popped this cycle, overwrite the tail dst in place (count unchanged, ready still 1). Coalescing is permitted when full.
- Dequeue: when count != 0 & ~wr_block & ~flush, pop the head and register btb_we=1, btb_jmpsrc/btb_jmpdst = head. Otherwise btb_we=0, and btb_jmpsrc/btb_jmpdst hold their last values.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: count unchanged, both pointers advance.
- Empty FIFO with a request: no bypass; the entry is written and popped on a later cycle.
- Flush: at the posedge, count, head and tail become 0 and btb_we becomes 0. An accept and a pop in the same cycle are both suppressed. prio is unchanged.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: btb_we=0, btb_jmpsrc=0, btb_jmpdst=0, count=0, prio=0, pointers=0. reqN_ready=0 while reset is high.
- Latency: request accepted at edge N into an empty FIFO with wr_block=0 -> btb_we=1 during cycle N+1 -> second accept can appear as btb_we in cycle N+2. The BTB samples the write on the negedge inside cycle N+1.
- Throughput: 1 update/cycle sustained.
- wr_block is sampled at the posedge. wr_block high at edge N -> btb_we=0 in cycle N+1, and the entry is retained.
- Reset mid-operation: all buffered updates are lost, with no partial write.

## Test plan
- Single update: req0 src=0x100 dst=0x200 at cycle 1 -> req0_ready=1 in cycle 1; btb_we=1 with 0x100/0x200 in cycle 2; count 1 then 0.
- Contention: both valid for 4 cycles with distinct srcs, prio=0 -> grants 0,1,0,1; btb_we writes in the same order one cycle later; no loss.
- Full/backpressure: wr_block=1, 5 distinct req0 updates -> first 4 accepted, count=4, ready=0 on 5th. Drop wr_block -> 4 writes in FIFO order, then the 5th is accepted.
- Coalesce: enqueue src=0x40 dst=0x80 with wr_block=1, then src=0x40 dst=0xC0 -> count stays 1. After release, a single write 0x40/0xC0.
- Flush: 3 entries queued with wr_block=1, assert flush with req1 valid -> req1_ready=0, count=0 next cycle, no btb_we afterward.
- Reset mid-stream: reset while count=2 and btb_we=1 -> next cycle btb_we=0, count=0, and prio=0 confirmed by a simultaneous request granting requester 0.

Source files
------------

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl
//   Write-port sequencer for the branch target buffer. Two branch-resolution
//   requesters offer resolved-taken updates; one is granted per cycle by a
//   1-bit round-robin pointer. Accepted updates are queued in a small FIFO
//   and drained onto the BTB's single write port at one update per cycle.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   reqN_valid/src/dst      update offered by requester N (N = 0, 1)
//   reqN_ready              requester N transferred this cycle (combinational)
//   flush                   drop every buffered update at the next edge
//   wr_block                hold off BTB writes this cycle (entries retained)
//   btb_we/jmpsrc/jmpdst    registered BTB write port
//   count                   registered FIFO occupancy
module btb_update_ctrl #(
  parameter int ADDR_LEN = 32,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [ADDR_LEN-1:0] req0_src,
  input  logic [ADDR_LEN-1:0] req0_dst,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [ADDR_LEN-1:0] req1_src,
  input  logic [ADDR_LEN-1:0] req1_dst,
  output logic                req1_ready,
  input  logic                flush,
  input  logic                wr_block,
  output logic                btb_we,
  output logic [ADDR_LEN-1:0] btb_jmpsrc,
  output logic [ADDR_LEN-1:0] btb_jmpdst,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // FIFO storage (no reset: occupancy decides which entries are meaningful)
  logic [ADDR_LEN-1:0] src_mem_q [DEPTH];
  logic [ADDR_LEN-1:0] dst_mem_q [DEPTH];

  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                prio_q, prio_d;
  logic                we_q, we_d;
  logic [ADDR_LEN-1:0] jmpsrc_q, jmpsrc_d;
  logic [ADDR_LEN-1:0] jmpdst_q, jmpdst_d;

  logic                any_valid;
  logic                gnt_idx;
  logic [ADDR_LEN-1:0] gnt_src;
  logic [ADDR_LEN-1:0] gnt_dst;
  logic [PTR_W-1:0]    tail_last;
  logic [PTR_W-1:0]    wr_idx;
  logic                empty;
  logic                full;
  logic                pop;
  logic                coalesce;
  logic                accept;
  logic                push;

  // Arbitration: contention resolved by prio; a lone requester always wins.
  assign any_valid = req0_valid | req1_valid;
  assign gnt_idx   = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign gnt_src   = gnt_idx ? req1_src : req0_src;
  assign gnt_dst   = gnt_idx ? req1_dst : req0_dst;

  assign tail_last = tail_q - PTR_W'(1);
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign pop       = ~empty & ~wr_block & ~flush;

  // Same branch PC as the newest queued entry: refresh its target in place.
  // Not allowed when that entry is the one leaving the FIFO this cycle.
  assign coalesce  = any_valid & ~empty & (src_mem_q[tail_last] == gnt_src) &
                     ~(pop & (count_q == CNT_W'(1)));

  // A full FIFO still accepts an update that only rewrites the tail.
  assign accept    = any_valid & ~flush & ~reset & (~full | coalesce);
  assign push      = accept & ~coalesce;
  assign wr_idx    = coalesce ? tail_last : tail_q;

  assign req0_ready = accept & ~gnt_idx;
  assign req1_ready = accept & gnt_idx;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    prio_d   = prio_q;
    we_d     = 1'b0;
    jmpsrc_d = jmpsrc_q;
    jmpdst_d = jmpdst_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        we_d     = 1'b1;
        jmpsrc_d = src_mem_q[head_q];
        jmpdst_d = dst_mem_q[head_q];
        head_d   = head_q + PTR_W'(1);
      end
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (accept) begin
        prio_d = ~gnt_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
      we_q     <= 1'b0;
      jmpsrc_q <= '0;
      jmpdst_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
      we_q     <= we_d;
      jmpsrc_q <= jmpsrc_d;
      jmpdst_q <= jmpdst_d;
    end
  end

  // Single write port serves both fresh enqueues and tail coalescing.
  always_ff @(posedge clk) begin
    if (accept) begin
      src_mem_q[wr_idx] <= gnt_src;
      dst_mem_q[wr_idx] <= gnt_dst;
    end
  end

  assign btb_we     = we_q;
  assign btb_jmpsrc = jmpsrc_q;
  assign btb_jmpdst = jmpdst_q;
  assign count      = count_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl
//   Directed table, hand-written flush / reset sequences and a random run,
//   all checked against a queue-based reference model of the write sequencer.
module tb_btb_update_ctrl;

  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic          clk;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_src, req0_dst, req1_src, req1_dst;
  logic          req0_ready, req1_ready;
  logic          flush, wr_block;
  logic          btb_we;
  logic [AW-1:0] btb_jmpsrc, btb_jmpdst;
  logic [CNT_W-1:0] count;

  btb_update_ctrl #(.ADDR_LEN(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_src   (req0_src),
    .req0_dst   (req0_dst),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_src   (req1_src),
    .req1_dst   (req1_dst),
    .req1_ready (req1_ready),
    .flush      (flush),
    .wr_block   (wr_block),
    .btb_we     (btb_we),
    .btb_jmpsrc (btb_jmpsrc),
    .btb_jmpdst (btb_jmpdst),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue of {src, dst}.
  typedef struct packed {
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
  } ent_t;

  ent_t          m_q[$];
  logic          m_prio;
  logic          m_we;
  logic [AW-1:0] m_src, m_dst;

  logic r0_s, r1_s;

  typedef struct {
    logic          r, f, wb;
    logic          v0;
    logic [AW-1:0] s0, d0;
    logic          v1;
    logic [AW-1:0] s1, d1;
    logic          er0, er1, ewe;
    logic [AW-1:0] esrc, edst;
    int            ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check ready mid-cycle, advance the model
  // at the edge, then check the registered outputs just after it.
  task automatic step(input logic r, input logic f, input logic wb,
                      input logic v0, input logic [AW-1:0] s0, input logic [AW-1:0] d0,
                      input logic v1, input logic [AW-1:0] s1, input logic [AW-1:0] d1);
    logic g, any, pop, coal, acc;
    logic [AW-1:0] gs, gd;
    ent_t e;
    reset = r; flush = f; wr_block = wb;
    req0_valid = v0; req0_src = s0; req0_dst = d0;
    req1_valid = v1; req1_src = s1; req1_dst = d1;

    any  = v0 | v1;
    g    = (v0 && v1) ? m_prio : v1;
    gs   = g ? s1 : s0;
    gd   = g ? d1 : d0;
    pop  = (m_q.size() != 0) && !wb && !f;
    coal = any && (m_q.size() != 0) && (m_q[m_q.size()-1].src == gs) &&
           !(pop && m_q.size() == 1);
    acc  = any && !f && !r && ((m_q.size() < DEPTH) || coal);

    @(negedge clk);
    r0_s = req0_ready;
    r1_s = req1_ready;
    chk("ready0", AW'(r0_s), AW'(acc && !g));
    chk("ready1", AW'(r1_s), AW'(acc && g));

    @(posedge clk);
    if (r) begin
      m_q.delete(); m_prio = 1'b0; m_we = 1'b0; m_src = '0; m_dst = '0;
    end else if (f) begin
      m_q.delete(); m_we = 1'b0;
    end else begin
      if (pop) begin
        e = m_q.pop_front();
        m_we = 1'b1; m_src = e.src; m_dst = e.dst;
      end else begin
        m_we = 1'b0;
      end
      if (acc) begin
        if (coal) begin
          e = m_q[m_q.size()-1];
          e.dst = gd;
          m_q[m_q.size()-1] = e;
        end else begin
          e.src = gs; e.dst = gd;
          m_q.push_back(e);
        end
        m_prio = !g;
      end
    end
    #1;
    chk("btb_we", AW'(btb_we), AW'(m_we));
    chk("btb_jmpsrc", btb_jmpsrc, m_src);
    chk("btb_jmpdst", btb_jmpdst, m_dst);
    chk("count", AW'(count), AW'(m_q.size()));
    $display("t=%0t rst=%b fl=%b wb=%b v0=%b s0=%h v1=%b s1=%h rdy=%b%b we=%b src=%h dst=%h cnt=%0d",
             $time, r, f, wb, v0, s0, v1, s1, r0_s, r1_s, btb_we, btb_jmpsrc, btb_jmpdst, count);
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic wb,
                              input logic v0, input logic [AW-1:0] s0, input logic [AW-1:0] d0,
                              input logic v1, input logic [AW-1:0] s1, input logic [AW-1:0] d1,
                              input logic er0, input logic er1, input logic ewe,
                              input logic [AW-1:0] esrc, input logic [AW-1:0] edst, input int ecnt);
    vec_t v;
    v.r = r; v.f = f; v.wb = wb;
    v.v0 = v0; v.s0 = s0; v.d0 = d0;
    v.v1 = v1; v.s1 = s1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1; v.ewe = ewe;
    v.esrc = esrc; v.edst = edst; v.ecnt = ecnt;
    return v;
  endfunction

  logic          p0v, p1v;
  logic [AW-1:0] p0s, p0d, p1s, p1d;
  logic          rr, rf, rwb;

  initial begin
    m_q.delete(); m_prio = 1'b0; m_we = 1'b0; m_src = '0; m_dst = '0;
    reset = 1'b1; flush = 1'b0; wr_block = 1'b0;
    req0_valid = 1'b0; req0_src = '0; req0_dst = '0;
    req1_valid = 1'b0; req1_src = '0; req1_dst = '0;
    r0_s = 1'b0; r1_s = 1'b0;
    @(posedge clk); #1;

    //            r f wb v0 s0      d0        v1 s1     d1      r0 r1 we src     dst      cnt
    tbl.push_back(mk(1,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 0,'h0,   'h0,     0));
    // single update
    tbl.push_back(mk(0,0,0, 1,'h100, 'h200,    0,'h0,   'h0,    1,0, 0,'h0,   'h0,     1));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 1,'h100, 'h200,   0));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 0,'h100, 'h200,   0));
    tbl.push_back(mk(1,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 0,'h0,   'h0,     0));
    // contention, prio starts at 0: grants 0,1,0,1
    tbl.push_back(mk(0,0,0, 1,'h10,  'h11,     1,'h20,  'h21,   1,0, 0,'h0,   'h0,     1));
    tbl.push_back(mk(0,0,0, 1,'h30,  'h31,     1,'h20,  'h21,   0,1, 1,'h10,  'h11,    1));
    tbl.push_back(mk(0,0,0, 1,'h30,  'h31,     1,'h40,  'h41,   1,0, 1,'h20,  'h21,    1));
    tbl.push_back(mk(0,0,0, 1,'h50,  'h51,     1,'h40,  'h41,   0,1, 1,'h30,  'h31,    1));
    tbl.push_back(mk(0,0,0, 1,'h50,  'h51,     0,'h0,   'h0,    1,0, 1,'h40,  'h41,    1));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 1,'h50,  'h51,    0));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 0,'h50,  'h51,    0));
    // coalesce under wr_block
    tbl.push_back(mk(0,0,1, 1,'h40,  'h80,     0,'h0,   'h0,    1,0, 0,'h50,  'h51,    1));
    tbl.push_back(mk(0,0,1, 1,'h40,  'hC0,     0,'h0,   'h0,    1,0, 0,'h50,  'h51,    1));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 1,'h40,  'hC0,    0));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 0,'h40,  'hC0,    0));
    // fill to full, coalesce while full, backpressure, then drain in order
    tbl.push_back(mk(0,0,1, 1,'h1,   'h1001,   0,'h0,   'h0,    1,0, 0,'h40,  'hC0,    1));
    tbl.push_back(mk(0,0,1, 1,'h2,   'h1002,   0,'h0,   'h0,    1,0, 0,'h40,  'hC0,    2));
    tbl.push_back(mk(0,0,1, 1,'h3,   'h1003,   0,'h0,   'h0,    1,0, 0,'h40,  'hC0,    3));
    tbl.push_back(mk(0,0,1, 1,'h4,   'h1004,   0,'h0,   'h0,    1,0, 0,'h40,  'hC0,    4));
    tbl.push_back(mk(0,0,1, 1,'h4,   'h2004,   0,'h0,   'h0,    1,0, 0,'h40,  'hC0,    4));
    tbl.push_back(mk(0,0,1, 1,'h5,   'h1005,   0,'h0,   'h0,    0,0, 0,'h40,  'hC0,    4));
    tbl.push_back(mk(0,0,0, 1,'h5,   'h1005,   0,'h0,   'h0,    0,0, 1,'h1,   'h1001,  3));
    tbl.push_back(mk(0,0,0, 1,'h5,   'h1005,   0,'h0,   'h0,    1,0, 1,'h2,   'h1002,  3));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 1,'h3,   'h1003,  2));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 1,'h4,   'h2004,  1));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 1,'h5,   'h1005,  0));
    tbl.push_back(mk(0,0,0, 0,'h0,   'h0,      0,'h0,   'h0,    0,0, 0,'h5,   'h1005,  0));

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].wb, tbl[i].v0, tbl[i].s0, tbl[i].d0,
           tbl[i].v1, tbl[i].s1, tbl[i].d1);
      chk($sformatf("tbl%0d_ready0", i), AW'(r0_s), AW'(tbl[i].er0));
      chk($sformatf("tbl%0d_ready1", i), AW'(r1_s), AW'(tbl[i].er1));
      chk($sformatf("tbl%0d_we", i), AW'(btb_we), AW'(tbl[i].ewe));
      chk($sformatf("tbl%0d_src", i), btb_jmpsrc, tbl[i].esrc);
      chk($sformatf("tbl%0d_dst", i), btb_jmpdst, tbl[i].edst);
      chk($sformatf("tbl%0d_count", i), AW'(count), AW'(tbl[i].ecnt));
    end

    // Flush with three queued entries and requester 1 pending.
    step(0,0,1, 1,'h7,'h70, 0,'h0,'h0);
    step(0,0,1, 1,'h8,'h80, 0,'h0,'h0);
    step(0,0,1, 1,'h9,'h90, 0,'h0,'h0);
    chk("flush_pre_count", AW'(count), AW'(3));
    step(0,1,0, 0,'h0,'h0, 1,'hA,'hA0);
    chk("flush_ready1", AW'(r1_s), AW'(0));
    chk("flush_count", AW'(count), AW'(0));
    chk("flush_we", AW'(btb_we), AW'(0));
    for (int k = 0; k < 2; k++) begin
      step(0,0,0, 0,'h0,'h0, 0,'h0,'h0);
      chk("post_flush_we", AW'(btb_we), AW'(0));
    end

    // Reset mid-stream: count=2 with a write in flight, prio left at 1.
    step(0,0,1, 1,'hB,'hB0, 0,'h0,'h0);
    step(0,0,1, 1,'hC,'hC0, 0,'h0,'h0);
    step(0,0,1, 1,'hD,'hD0, 0,'h0,'h0);
    step(0,0,0, 0,'h0,'h0, 0,'h0,'h0);
    chk("pre_rst_we", AW'(btb_we), AW'(1));
    chk("pre_rst_count", AW'(count), AW'(2));
    step(1,0,0, 1,'hE,'hE0, 0,'h0,'h0);
    chk("rst_ready0", AW'(r0_s), AW'(0));
    chk("rst_we", AW'(btb_we), AW'(0));
    chk("rst_count", AW'(count), AW'(0));
    step(0,0,0, 1,'hE,'hE0, 1,'hF,'hF0);
    chk("rst_prio_ready0", AW'(r0_s), AW'(1));
    chk("rst_prio_ready1", AW'(r1_s), AW'(0));

    // Random traffic; a requester keeps its offer until it is accepted.
    p0v = 1'b0; p1v = 1'b0;
    p0s = '0; p0d = '0; p1s = '0; p1d = '0;
    r0_s = 1'b1; r1_s = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (!p0v || r0_s) begin
        p0v = ($urandom_range(0, 2) != 0);
        p0s = AW'($urandom_range(0, 7) * 4);
        p0d = AW'($urandom);
      end
      if (!p1v || r1_s) begin
        p1v = ($urandom_range(0, 2) != 0);
        p1s = AW'($urandom_range(0, 7) * 4);
        p1d = AW'($urandom);
      end
      rr  = ($urandom_range(0, 99) == 0);
      rf  = ($urandom_range(0, 29) == 0);
      rwb = ($urandom_range(0, 3) == 0);
      step(rr, rf, rwb, p0v, p0s, p0d, p1v, p1s, p1d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
